// File: rtl/mem_access_ctrl_if.sv
// Interface bundling the request/response and data-bus signals of
// mem_access_ctrl.
//   slave  : controller view (takes requests, drives responses and the bus).
//   master : environment view (pipeline + memory side).
// Request : req_valid, req_ready, req_op, req_addr, req_wdata
// Response: resp_valid, resp_rdata, resp_err
// Bus     : bus_req, bus_we, bus_addr, bus_wdata, bus_gnt, bus_rvalid, bus_rdata
interface mem_access_ctrl_if #(
  parameter int unsigned CPU_WIDTH    = 32,
  parameter int unsigned MEM_OP_WIDTH = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [MEM_OP_WIDTH-1:0] req_op;
  logic [CPU_WIDTH-1:0]    req_addr;
  logic [CPU_WIDTH-1:0]    req_wdata;
  logic                    resp_valid;
  logic [CPU_WIDTH-1:0]    resp_rdata;
  logic                    resp_err;
  logic                    bus_req;
  logic                    bus_we;
  logic [CPU_WIDTH-1:0]    bus_addr;
  logic [CPU_WIDTH-1:0]    bus_wdata;
  logic                    bus_gnt;
  logic                    bus_rvalid;
  logic [CPU_WIDTH-1:0]    bus_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Accepts one load/store at a time, issues word-aligned transactions on a
// req/gnt/rvalid bus, performs sub-word stores as read-modify-write and
// sign/zero-extends load data. Misaligned accesses complete with resp_err
// and no bus activity.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   io  : mem_access_ctrl_if.slave (request, response and bus signals)
module mem_access_ctrl #(
  parameter int unsigned CPU_WIDTH    = 32,
  parameter int unsigned MEM_OP_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   io
);

  localparam logic [MEM_OP_WIDTH-1:0] OP_NONE = MEM_OP_WIDTH'(0);
  localparam logic [MEM_OP_WIDTH-1:0] OP_LB   = MEM_OP_WIDTH'(1);
  localparam logic [MEM_OP_WIDTH-1:0] OP_LH   = MEM_OP_WIDTH'(2);
  localparam logic [MEM_OP_WIDTH-1:0] OP_LW   = MEM_OP_WIDTH'(3);
  localparam logic [MEM_OP_WIDTH-1:0] OP_LBU  = MEM_OP_WIDTH'(4);
  localparam logic [MEM_OP_WIDTH-1:0] OP_LHU  = MEM_OP_WIDTH'(5);
  localparam logic [MEM_OP_WIDTH-1:0] OP_SB   = MEM_OP_WIDTH'(6);
  localparam logic [MEM_OP_WIDTH-1:0] OP_SH   = MEM_OP_WIDTH'(7);
  localparam logic [MEM_OP_WIDTH-1:0] OP_SW   = MEM_OP_WIDTH'(8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [MEM_OP_WIDTH-1:0] op_q;
  logic [1:0]              lane_q;
  logic [15:0]             src_q;
  logic [CPU_WIDTH-1:0]    bus_addr_q;
  logic [CPU_WIDTH-1:0]    bus_wdata_q;
  logic [CPU_WIDTH-1:0]    resp_rdata_q;
  logic                    resp_err_q;

  // Decode of the incoming request (only meaningful in IDLE)
  logic req_is_load, req_is_sub_store, req_is_sw, req_mis, req_none;

  always_comb begin
    req_is_load      = 1'b0;
    req_is_sub_store = 1'b0;
    req_is_sw        = 1'b0;
    req_mis          = 1'b0;
    case (io.req_op)
      OP_LB, OP_LBU: req_is_load = 1'b1;
      OP_LH, OP_LHU: begin
        req_is_load = 1'b1;
        req_mis     = io.req_addr[0];
      end
      OP_LW: begin
        req_is_load = 1'b1;
        req_mis     = |io.req_addr[1:0];
      end
      OP_SB: req_is_sub_store = 1'b1;
      OP_SH: begin
        req_is_sub_store = 1'b1;
        req_mis          = io.req_addr[0];
      end
      OP_SW: begin
        req_is_sw = 1'b1;
        req_mis   = |io.req_addr[1:0];
      end
      default: ;
    endcase
    req_none = !(req_is_load || req_is_sub_store || req_is_sw);
  end

  logic op_q_is_load;
  assign op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LHU);

  // Load extraction and store merge, both working on the returned bus word
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [CPU_WIDTH-1:0] load_data;
  logic [CPU_WIDTH-1:0] merged;

  always_comb begin
    rd_byte   = io.bus_rdata[{lane_q, 3'b000} +: 8];
    rd_half   = io.bus_rdata[{lane_q[1], 4'b0000} +: 16];
    load_data = '0;
    case (op_q)
      OP_LB:   load_data = {{(CPU_WIDTH-8){rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {{(CPU_WIDTH-8){1'b0}}, rd_byte};
      OP_LH:   load_data = {{(CPU_WIDTH-16){rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {{(CPU_WIDTH-16){1'b0}}, rd_half};
      OP_LW:   load_data = io.bus_rdata;
      default: load_data = '0;
    endcase

    merged = io.bus_rdata;
    if (op_q == OP_SB) begin
      merged[{lane_q, 3'b000} +: 8] = src_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = src_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    io.req_ready  = 1'b0;
    io.resp_valid = 1'b0;
    io.bus_req    = 1'b0;
    io.bus_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) begin
          if (req_none || req_mis) begin
            state_d = ST_DONE;
          end else if (req_is_sw) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        io.bus_req = 1'b1;
        if (io.bus_gnt) state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (io.bus_rvalid) state_d = op_q_is_load ? ST_DONE : ST_WR;
      end
      ST_WR: begin
        io.bus_req = 1'b1;
        io.bus_we  = 1'b1;
        if (io.bus_gnt) state_d = ST_DONE;
      end
      ST_DONE: begin
        io.resp_valid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers only change on the cycle that enters DONE, so they
  // hold their last values at all other times.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_NONE;
      lane_q       <= '0;
      src_q        <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.req_valid) begin
            op_q       <= io.req_op;
            lane_q     <= io.req_addr[1:0];
            src_q      <= io.req_wdata[15:0];
            bus_addr_q <= {io.req_addr[CPU_WIDTH-1:2], 2'b00};
            if (req_is_sw) bus_wdata_q <= io.req_wdata;
            if (req_none || req_mis) begin
              resp_rdata_q <= '0;
              resp_err_q   <= req_mis;
            end
          end
        end
        ST_RWAIT: begin
          if (io.bus_rvalid) begin
            if (op_q_is_load) begin
              resp_rdata_q <= load_data;
              resp_err_q   <= 1'b0;
            end else begin
              bus_wdata_q <= merged;
            end
          end
        end
        ST_WR: begin
          if (io.bus_gnt) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.bus_addr   = bus_addr_q;
  assign io.bus_wdata  = bus_wdata_q;
  assign io.resp_rdata = resp_rdata_q;
  assign io.resp_err   = resp_err_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory access controller directly downstream of the store-data mux in the MEM stage of the rvseed core.
- Accepts one load/store request at a time and issues word-aligned transactions on a simple req/gnt/rvalid data bus.
- The bus has no byte strobes, so sub-word stores are performed as read-modify-write. Load data is extracted and sign- or zero-extended.
- Holds the pipeline via req_ready until the response is returned.

Parameters:
- CPU_WIDTH, 32, data/address width.
- MEM_OP_WIDTH, 4, opcode width. Codes: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW. Codes 9-15 are treated as NONE.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  MEM_OP_WIDTH  memory opcode.
- req_addr  in  CPU_WIDTH  byte address.
- req_wdata  in  CPU_WIDTH  store source (rs2 value, low bits significant).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  CPU_WIDTH  extended load data; 0 for stores/NONE/error.
- resp_err  out  1  misaligned-access flag, valid with resp_valid.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  CPU_WIDTH  word address ({req_addr[31:2],2'b00}).
- bus_wdata  out  CPU_WIDTH  full write word.
- bus_gnt  in  1  transaction accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  CPU_WIDTH  read data word.

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; bus_req=0; bus_we=0; bus_addr=0; bus_wdata=0.
- Reset mid-operation: next cycle is IDLE and bus_req=0. The in-flight transaction is abandoned; a later bus_rvalid is ignored.
- Acceptance: handshake when req_valid & req_ready. req_ready=1 only in IDLE. On handshake, op/addr/wdata are latched; inputs are don't-care afterwards.
- FSM states: IDLE, RD, RWAIT, WR, DONE.
  - IDLE -> RD: loads and SB/SH.
  - IDLE -> WR: SW.
  - IDLE -> DONE: NONE, or misaligned access (resp_err=1, no bus activity).
  - RD: bus_req=1, bus_we=0; stay until bus_gnt, then RWAIT.
  - RWAIT: bus_req=0; wait for bus_rvalid and capture bus_rdata. Loads -> DONE; SB/SH -> WR.
  - WR: bus_req=1, bus_we=1, bus_wdata = merged word; stay until bus_gnt, then DONE.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE (req_ready=1 the following cycle).
- bus_req/bus_we/bus_addr/bus_wdata are stable while waiting for bus_gnt. bus_rvalid is sampled only in RWAIT. The bus guarantees rvalid ≥1 cycle after gnt.
- Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Byte ops are never misaligned.
- Load extract: lane = addr[1:0] for bytes, addr[1] for halves.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge: SB replaces byte lane addr[1:0] of the read word with wdata[7:0]. SH replaces half addr[1] with wdata[15:0]. SW writes wdata as-is.
- Minimum latency, handshake cycle = 0, gnt same cycle as request:
  - SW/NONE/error: resp_valid at cycle 2 (NONE/error at cycle 1).
  - Loads: gnt in cycle 1, rvalid in cycle 2, resp_valid at cycle 3.
  - SB/SH: add one WR cycle, resp_valid at cycle 4.
- resp_rdata/resp_err hold their last values outside DONE. They are meaningful only when resp_valid=1.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt immediate -> one write: bus_addr 0x100, bus_wdata 0xDEADBEEF; resp_valid at cycle 2; no read issued.
- LB addr 0x203, bus_rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80. Repeat as LBU -> 0x00000080. LHU addr 0x202 -> 0x000080FF.
- SB addr 0x301, wdata 0x000000AA, read returns 0x11223344 -> read then write 0x1122AA44 to 0x300; resp_valid after the write gnt.
- Misaligned LW addr 0x102 and SH addr 0x105 -> resp_err=1, resp_rdata=0, bus_req never asserted, resp_valid at cycle 1.
- Bus backpressure: bus_gnt held low 5 cycles, rvalid 3 cycles after gnt -> bus_req/addr stable throughout; req_ready=0 until after resp_valid; back-to-back req_valid accepted only in IDLE.
- rst asserted in RWAIT, then a stray bus_rvalid -> outputs return to reset values next cycle; no resp_valid; next LW completes normally.
